// File: rtl/ay_bus_pkg.sv
// ---------------------------------------------------------------------------
// ay_bus_pkg
// Shared types for the AY/YM (TurboSound) bus initiator:
//   bus_mode_e    - {BDIR,BC} encodings driven onto the AY bus
//   ay_req_t      - one queued register access {write, chip, reg_idx, data}
//   seq_state_e   - bus sequencer phase states
//   TS_SEL_PREFIX - upper 7 bits of the TurboSound chip-select latch value
//   mode_of()     - bus mode driven while in a given sequencer state
// ---------------------------------------------------------------------------
package ay_bus_pkg;

   typedef enum logic [1:0] {
      BUS_INACT = 2'b00,
      BUS_READ  = 2'b01,
      BUS_WRITE = 2'b10,
      BUS_LATCH = 2'b11
   } bus_mode_e;

   typedef struct packed {
      logic       write;
      logic       chip;
      logic [3:0] reg_idx;
      logic [7:0] data;
   } ay_req_t;

   localparam logic [6:0] TS_SEL_PREFIX = 7'h7F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_GAP1,
      ST_ADDR,
      ST_GAP2,
      ST_WR,
      ST_RD,
      ST_GAP3
   } seq_state_e;

   function automatic bus_mode_e mode_of(input seq_state_e s);
      case (s)
         ST_SEL, ST_ADDR: return BUS_LATCH;
         ST_WR:           return BUS_WRITE;
         ST_RD:           return BUS_READ;
         default:         return BUS_INACT;
      endcase
   endfunction

endpackage

// File: rtl/ay_req_fifo.sv
// ---------------------------------------------------------------------------
// ay_req_fifo
// First-word-fall-through request queue of ay_req_t entries.
//   CLK, RESET      - clock, asynchronous active-high reset (empties queue)
//   push_i / push_data_i - write an entry (caller guarantees not full)
//   pop_i           - drop the head entry (caller guarantees not empty)
//   head_o          - current head entry, valid whenever empty_o is low
//   full_o, empty_o - occupancy flags
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ay_req_fifo
   import ay_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic    CLK,
   input  logic    RESET,
   input  logic    push_i,
   input  ay_req_t push_data_i,
   input  logic    pop_i,
   output ay_req_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int         AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   ay_req_t       mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/ay_bus_sequencer.sv
// ---------------------------------------------------------------------------
// ay_bus_sequencer
// Bus-initiator for a dual AY/YM (TurboSound) block. Queues register
// read/write requests and plays them out as BDIR/BC/DA cycles paced by the
// PSG clock enable CE. A chip-select latch (8'hFE|chip) is emitted only when
// the target chip differs from the last one selected.
//   CLK, RESET  - system clock, asynchronous active-high reset
//   CE          - PSG clock enable; every phase length is counted in CE pulses
//   req_*       - request handshake (accepted on req_valid & req_ready)
//   rsp_valid/rsp_data - one-CLK pulse with read data; data held until next read
//   BDIR, BC, DA_out   - registered AY bus outputs; DA_in - data from the AY
//   busy        - queue non-empty or a bus sequence in progress
// ---------------------------------------------------------------------------
module ay_bus_sequencer
   import ay_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int HOLD_CE    = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CE,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic       req_chip,
   input  logic [3:0] req_reg,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       BDIR,
   output logic       BC,
   output logic [7:0] DA_out,
   input  logic [7:0] DA_in,
   output logic       busy
);

   localparam logic [3:0] LAST_PULSE = 4'(HOLD_CE - 1);

   seq_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cur_chip_q, cur_chip_d;
   ay_req_t    req_q, req_d;
   bus_mode_e  mode_q, mode_d;
   logic [7:0] da_q, da_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   ay_req_t    push_req;
   ay_req_t    head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   logic       phase_last;

   assign push_req  = {req_write, req_chip, req_reg, req_data};
   assign req_ready = !fifo_full;
   assign push      = req_valid & req_ready;

   ay_req_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK         (CLK),
      .RESET       (RESET),
      .push_i      (push),
      .push_data_i (push_req),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign phase_last = (cnt_q == LAST_PULSE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_chip_d  = cur_chip_q;
      req_d       = req_q;
      pop         = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;

      if (CE) begin
         case (state_q)
            // GAP3 shares the IDLE start logic so queued requests run back-to-back.
            ST_IDLE, ST_GAP3: begin
               cnt_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  req_d   = head;
                  state_d = (head.chip != cur_chip_q) ? ST_SEL : ST_ADDR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SEL: begin
               if (phase_last) begin
                  state_d    = ST_GAP1;
                  cnt_d      = '0;
                  cur_chip_d = req_q.chip;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            ST_GAP1: state_d = ST_ADDR;
            ST_ADDR: begin
               if (phase_last) begin
                  state_d = ST_GAP2;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            ST_GAP2: state_d = req_q.write ? ST_WR : ST_RD;
            ST_WR: begin
               if (phase_last) begin
                  state_d = ST_GAP3;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            // Read data is captured on the final CE of the READ phase.
            ST_RD: begin
               if (phase_last) begin
                  state_d     = ST_GAP3;
                  cnt_d       = '0;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = DA_in;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Bus outputs are registered from the next state so they change on the
      // same edge as the phase and stay constant across it.
      mode_d = mode_of(state_d);
      case (state_d)
         ST_SEL:  da_d = {TS_SEL_PREFIX, req_d.chip};
         ST_ADDR: da_d = {4'h0, req_d.reg_idx};
         ST_WR:   da_d = req_d.data;
         default: da_d = 8'h00;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cur_chip_q  <= 1'b1;
         mode_q      <= BUS_INACT;
         da_q        <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_chip_q  <= cur_chip_d;
         mode_q      <= mode_d;
         da_q        <= da_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_ff @(posedge CLK) begin
      req_q <= req_d;
   end

   assign BDIR      = mode_q[1];
   assign BC        = mode_q[0];
   assign DA_out    = da_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
